// File: rtl/regfile_pkg.sv
// Shared constants and grant-port encoding for the register-file writeback arbiter.
package regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic {
    GRANT_P0 = 1'b0,
    GRANT_P1 = 1'b1
  } grant_port_e;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle for the writeback arbiter: two request ports, the register-file write port,
// and the issue-stage reservation / pending-write scoreboard.
interface regfile_wb_if #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
);
  // valid/ready: a requester raises valid with rd/data and holds all three unchanged until a
  // rising edge where its ready is also high; that edge is the transfer. ready is only ever
  // high for the one granted port, and only while that port's valid is high.
  logic                 req0_valid;
  logic                 req0_ready;
  logic [ADDR_W-1:0]    req0_rd;
  logic [DATA_W-1:0]    req0_data;
  logic                 req1_valid;
  logic                 req1_ready;
  logic [ADDR_W-1:0]    req1_rd;
  logic [DATA_W-1:0]    req1_data;
  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_rd;
  logic [DATA_W-1:0]    wr_data;
  logic                 alloc_valid;
  logic [ADDR_W-1:0]    alloc_rd;
  logic [2**ADDR_W-1:0] reg_busy;

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    input  req1_valid, req1_rd, req1_data,
    input  alloc_valid, alloc_rd,
    output req0_ready, req1_ready,
    output wr_en, wr_rd, wr_data,
    output reg_busy
  );

  modport master (
    output req0_valid, req0_rd, req0_data,
    output req1_valid, req1_rd, req1_data,
    output alloc_valid, alloc_rd,
    input  req0_ready, req1_ready,
    input  wr_en, wr_rd, wr_data,
    input  reg_busy
  );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant from valids; on contention the port not granted last wins.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  valid,
  output logic [1:0]  grant,
  output grant_port_e last_grant
);
  grant_port_e last_q, last_d;

  always_comb begin
    grant  = 2'b00;
    last_d = last_q;
    if (!rst) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (last_q == GRANT_P1) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
    // Every grant is a transfer because ready mirrors grant, so history moves on any grant.
    if (grant[0]) begin
      last_d = GRANT_P0;
    end else if (grant[1]) begin
      last_d = GRANT_P1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= GRANT_P1;
    end else begin
      last_q <= last_d;
    end
  end

  assign last_grant = last_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: merges ALU (port 0) and LSU (port 1) results into one register-file write port.
// Optional pending-write scoreboard enabled by defining REGFILE_WB_SCOREBOARD_EN.
module regfile_wb_arbiter #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  regfile_wb_if.slave              bus,
  output regfile_pkg::grant_port_e dbg_last_grant
);
  import regfile_pkg::*;

  localparam int NREGS = 2 ** ADDR_W;

  logic [1:0]        grant;
  logic              xfer;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_rd_q, wr_rd_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .valid      ({bus.req1_valid, bus.req0_valid}),
    .grant      (grant),
    .last_grant (dbg_last_grant)
  );

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  always_comb begin
    xfer      = |grant;
    sel_rd    = grant[1] ? bus.req1_rd   : bus.req0_rd;
    sel_data  = grant[1] ? bus.req1_data : bus.req0_data;
    // rd 0 is the hardwired zero register: the grant is consumed but nothing is written.
    wr_en_d   = xfer && (sel_rd != '0);
    wr_rd_d   = wr_rd_q;
    wr_data_d = wr_data_q;
    if (xfer) begin
      wr_rd_d   = sel_rd;
      wr_data_d = sel_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_rd_q   <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_rd_q   <= wr_rd_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_rd   = wr_rd_q;
  assign bus.wr_data = wr_data_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
  logic [NREGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (wr_en_d) begin
      busy_d[sel_rd] = 1'b0;
    end
    // A same-edge reservation comes from a newer producer, so it overrides the clear.
    if (bus.alloc_valid) begin
      busy_d[bus.alloc_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign bus.reg_busy = busy_q;
`else
  logic unused_alloc;
  assign unused_alloc = ^{bus.alloc_valid, bus.alloc_rd, NREGS[0]};
  assign bus.reg_busy = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter against a rule-level reference model.
module tb_regfile_wb_arbiter;
  logic clk;
  logic rst;
  regfile_pkg::grant_port_e dbg_last_grant;

  regfile_wb_if bus ();

  regfile_wb_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .dbg_last_grant (dbg_last_grant)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  int          last_m;
  logic [31:0] busy_m;
  logic [36:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_busy();
`ifdef REGFILE_WB_SCOREBOARD_EN
    return busy_m;
`else
    return 32'h0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int p, input logic [4:0] rd, input logic [31:0] d);
    if (p == 0) begin
      bus.req0_valid = 1'b1; bus.req0_rd = rd; bus.req0_data = d;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_rd = rd; bus.req1_data = d;
    end
  endtask

  task automatic alloc(input logic [4:0] rd);
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = rd;
  endtask

  // One clock: check readies mid-cycle, apply the rules at the edge, check registered outputs.
  task automatic step();
    int          g;
    logic [4:0]  rd;
    logic [31:0] d;
    logic        exp_en;
    logic [36:0] w;
    @(negedge clk);
    g = -1;
    if (bus.req0_valid && bus.req1_valid) g = (last_m == 1) ? 0 : 1;
    else if (bus.req0_valid)             g = 0;
    else if (bus.req1_valid)             g = 1;
    rd = (g == 1) ? bus.req1_rd   : bus.req0_rd;
    d  = (g == 1) ? bus.req1_data : bus.req0_data;
    check("req0_ready", {63'd0, bus.req0_ready}, {63'd0, g == 0});
    check("req1_ready", {63'd0, bus.req1_ready}, {63'd0, g == 1});
    @(posedge clk);
    #1;
    exp_en = 1'b0;
    if (g >= 0) begin
      last_m = g;
      if (rd != 5'd0) begin
        exp_q.push_back({rd, d});
        busy_m[rd] = 1'b0;
        exp_en = 1'b1;
      end
      if (g == 0) bus.req0_valid = 1'b0;
      else        bus.req1_valid = 1'b0;
    end
    if (bus.alloc_valid && bus.alloc_rd != 5'd0) busy_m[bus.alloc_rd] = 1'b1;
    bus.alloc_valid = 1'b0;
    check("wr_en", {63'd0, bus.wr_en}, {63'd0, exp_en});
    if (exp_en && exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check("wr_rd", {59'd0, bus.wr_rd}, {59'd0, w[36:32]});
      check("wr_data", {32'd0, bus.wr_data}, {32'd0, w[31:0]});
    end
    check("reg_busy", {32'd0, bus.reg_busy}, {32'd0, exp_busy()});
  endtask

  // Raise rst just after an edge, check outputs drop at once, release one cycle later.
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_wr_en", {63'd0, bus.wr_en}, 64'd0);
    check("rst_wr_rd", {59'd0, bus.wr_rd}, 64'd0);
    check("rst_wr_data", {32'd0, bus.wr_data}, 64'd0);
    check("rst_reg_busy", {32'd0, bus.reg_busy}, 64'd0);
    check("rst_req0_ready", {63'd0, bus.req0_ready}, 64'd0);
    check("rst_req1_ready", {63'd0, bus.req1_ready}, 64'd0);
    exp_q.delete();
    last_m = 1;
    busy_m = '0;
    bus.alloc_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    while (bus.req0_valid || bus.req1_valid) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_rd = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_rd = '0; bus.req1_data = '0;
    bus.alloc_valid = 1'b0; bus.alloc_rd = '0;
    last_m = 1;
    busy_m = '0;
    repeat (2) @(posedge clk);
    #1;
    apply_reset();

    // Single ALU writeback, latency one.
    drive(0, 5'd5, 32'hDEADBEEF);
    step();
    step();

    // Sustained contention: alternate grants, one write per cycle.
    for (int i = 0; i < 4; i++) begin
      if (!bus.req0_valid) drive(0, 5'd1, $urandom);
      if (!bus.req1_valid) drive(1, 5'd2, $urandom);
      step();
    end
    drain();

    // rd 0 consumes the grant without a write; next contention goes to port 0.
    drive(1, 5'd0, 32'h1234);
    step();
    drive(0, 5'd9, $urandom);
    drive(1, 5'd10, $urandom);
    step();
    drain();

    // Reservation set and clear; same-edge reservation wins.
    alloc(5'd7);
    step();
    drive(0, 5'd7, $urandom);
    step();
    drive(0, 5'd7, $urandom);
    alloc(5'd7);
    step();
    alloc(5'd3);
    step();
    drive(0, 5'd7, $urandom);
    step();

    // Reset while a write is in flight and both ports are waiting.
    drive(0, 5'd11, $urandom);
    drive(1, 5'd12, $urandom);
    step();
    if (!bus.req0_valid) drive(0, 5'd11, $urandom);
    if (!bus.req1_valid) drive(1, 5'd12, $urandom);
    apply_reset();
    step();
    drain();

    // Randomized traffic with occasional reservations and resets.
    for (int i = 0; i < 400; i++) begin
      if (!bus.req0_valid && $urandom_range(0, 2) != 0) drive(0, 5'($urandom_range(0, 31)), $urandom);
      if (!bus.req1_valid && $urandom_range(0, 2) != 0) drive(1, 5'($urandom_range(0, 31)), $urandom);
      if ($urandom_range(0, 3) == 0) alloc(5'($urandom_range(0, 31)));
      if ($urandom_range(0, 99) == 0) apply_reset();
      else step();
    end
    drain();
    step();

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
